// File: rtl/connection_encoder.sv
// connection_encoder: turns decoded connection entries back into puzzle text
// lines of the form "abc: def ghi\n", one registered byte per handshake.
module connection_encoder #(
  parameter int DEVICE_CHARS    = 3,
  parameter int DEVICE_BIN_BITS = 5,
  parameter int DEVICE_WIDTH    = DEVICE_CHARS * DEVICE_BIN_BITS,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    test_logic_reset,
  input  logic                    connection_valid,
  output logic                    connection_ready,
  input  logic                    connection_last,
  input  logic [DEVICE_WIDTH-1:0] device,
  input  logic [DEVICE_WIDTH-1:0] next_device,
  input  logic                    end_of_file,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic [7:0]              byte_data,
  output logic                    end_of_stream,
  output logic [COUNT_WIDTH-1:0]  byte_count,
  output logic                    protocol_error
);

  localparam int IDX_WIDTH = (DEVICE_CHARS > 1) ? $clog2(DEVICE_CHARS) : 1;
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DEVICE_CHARS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SRC,
    COLON,
    SEP,
    DST,
    NEWLINE,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_d;
  logic [IDX_WIDTH-1:0]    idx;
  logic [IDX_WIDTH-1:0]    idx_d;
  logic [DEVICE_WIDTH-1:0] device_q;
  logic [DEVICE_WIDTH-1:0] device_d;
  logic [DEVICE_WIDTH-1:0] next_q;
  logic [DEVICE_WIDTH-1:0] next_d;
  logic                    last_q;
  logic                    last_d;
  logic                    line_open;
  logic                    line_open_d;
  logic                    eof_pending;
  logic                    accept;
  logic                    fire;
  logic                    mismatch;
  logic                    byte_valid_d;
  logic                    byte_bad_d;
  logic [7:0]              byte_d;

  // Maps one character of a packed device name to ASCII; bit 8 flags an
  // out-of-alphabet code, which is rendered as '?'.
  function automatic logic [8:0] encode_char(
    input logic [DEVICE_WIDTH-1:0] word,
    input logic [IDX_WIDTH-1:0]    pos
  );
    logic [DEVICE_BIN_BITS-1:0] code;
    logic [7:0]                 ch;
    logic                       bad;
    code = '0;
    for (int k = 0; k < DEVICE_CHARS; k++) begin
      if (pos == IDX_WIDTH'(k)) begin
        code = word[(DEVICE_CHARS-1-k)*DEVICE_BIN_BITS +: DEVICE_BIN_BITS];
      end
    end
    if (32'(code) < 32'd26) begin
      ch  = 8'h61 + 8'(code);
      bad = 1'b0;
    end else begin
      ch  = 8'h3F;
      bad = 1'b1;
    end
    return {bad, ch};
  endfunction

  // New entries are taken only when the encoder is idle with nothing on the
  // byte port and no end-of-file waiting to be acted on.
  assign connection_ready = (state == IDLE) && !eof_pending && !byte_valid && !test_logic_reset;
  assign accept           = connection_valid && connection_ready;
  assign fire             = byte_valid && byte_ready;
  assign mismatch         = accept && line_open && (device != device_q);

  // State register.
  always_ff @(posedge clk) begin
    if (test_logic_reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic: walks the characters of a line segment, advancing only
  // when the sink takes the current byte.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    device_d    = device_q;
    next_d      = next_q;
    last_d      = last_q;
    line_open_d = line_open;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next_d = next_device;
          last_d = connection_last;
          idx_d  = '0;
          if (line_open) begin
            state_d = SEP;
          end else begin
            device_d = device;
            state_d  = SRC;
          end
        end else if (eof_pending) begin
          state_d = line_open ? NEWLINE : DONE;
        end
      end
      SRC: begin
        if (fire) begin
          if (idx == IDX_LAST) begin
            idx_d   = '0;
            state_d = COLON;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      COLON: begin
        if (fire) begin
          state_d = SEP;
        end
      end
      SEP: begin
        if (fire) begin
          idx_d   = '0;
          state_d = DST;
        end
      end
      DST: begin
        if (fire) begin
          if (idx == IDX_LAST) begin
            idx_d = '0;
            if (last_q) begin
              state_d = NEWLINE;
            end else begin
              line_open_d = 1'b1;
              state_d     = IDLE;
            end
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      NEWLINE: begin
        if (fire) begin
          line_open_d = 1'b0;
          state_d     = (eof_pending || end_of_file) ? DONE : IDLE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: the byte to present next cycle, derived from where the FSM
  // is heading so the byte register loads together with the state.
  always_comb begin
    byte_valid_d = 1'b0;
    byte_bad_d   = 1'b0;
    byte_d       = byte_data;
    unique case (state_d)
      SRC: begin
        {byte_bad_d, byte_d} = encode_char(device_d, idx_d);
        byte_valid_d         = 1'b1;
      end
      COLON: begin
        byte_d       = 8'h3A;
        byte_valid_d = 1'b1;
      end
      SEP: begin
        byte_d       = 8'h20;
        byte_valid_d = 1'b1;
      end
      DST: begin
        {byte_bad_d, byte_d} = encode_char(next_d, idx_d);
        byte_valid_d         = 1'b1;
      end
      NEWLINE: begin
        byte_d       = 8'h0A;
        byte_valid_d = 1'b1;
      end
      default: begin
        byte_valid_d = 1'b0;
      end
    endcase
  end

  // Entry capture and line bookkeeping; device_q keeps the source of the open
  // line so continuation entries can be checked against it.
  always_ff @(posedge clk) begin
    if (test_logic_reset) begin
      idx         <= '0;
      device_q    <= '0;
      next_q      <= '0;
      last_q      <= 1'b0;
      line_open   <= 1'b0;
      eof_pending <= 1'b0;
    end else begin
      idx         <= idx_d;
      device_q    <= device_d;
      next_q      <= next_d;
      last_q      <= last_d;
      line_open   <= line_open_d;
      eof_pending <= eof_pending || end_of_file;
    end
  end

  // Registered byte port, end-of-stream pulse, byte counter and sticky error.
  always_ff @(posedge clk) begin
    if (test_logic_reset) begin
      byte_valid     <= 1'b0;
      byte_data      <= 8'h00;
      end_of_stream  <= 1'b0;
      byte_count     <= '0;
      protocol_error <= 1'b0;
    end else begin
      byte_valid <= byte_valid_d;
      if (byte_valid_d) begin
        byte_data <= byte_d;
      end
      end_of_stream <= (state_d == DONE) && (state != DONE);
      if (fire && (byte_count != {COUNT_WIDTH{1'b1}})) begin
        byte_count <= byte_count + COUNT_WIDTH'(1);
      end
      protocol_error <= protocol_error || (byte_valid_d && byte_bad_d) || mismatch;
    end
  end

endmodule

// File: tb/tb_connection_encoder.sv
// tb_connection_encoder: scoreboard bench; a text-level model pushes the
// expected bytes when entries are issued and a monitor pops them on handshakes.
module tb_connection_encoder;

  localparam int CH = 3;
  localparam int BB = 5;
  localparam int DW = CH * BB;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          test_logic_reset = 1'b1;
  logic          connection_valid = 1'b0;
  logic          connection_ready;
  logic          connection_last = 1'b0;
  logic [DW-1:0] device = '0;
  logic [DW-1:0] next_device = '0;
  logic          end_of_file = 1'b0;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic [7:0]    byte_data;
  logic          end_of_stream;
  logic [CW-1:0] byte_count;
  logic          protocol_error;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         eof_issued = 1'b0;
  bit         eos_due = 1'b0;
  bit         eos_prev = 1'b0;
  bit         held = 1'b0;
  logic [7:0] held_data = 8'h00;
  int         eos_count = 0;
  int         ready_mode = 1;

  bit            m_open = 1'b0;
  logic [DW-1:0] m_src = '0;
  bit            m_err = 1'b0;
  int            m_count = 0;

  connection_encoder dut (
    .clk              (clk),
    .test_logic_reset (test_logic_reset),
    .connection_valid (connection_valid),
    .connection_ready (connection_ready),
    .connection_last  (connection_last),
    .device           (device),
    .next_device      (next_device),
    .end_of_file      (end_of_file),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .byte_data        (byte_data),
    .end_of_stream    (end_of_stream),
    .byte_count       (byte_count),
    .protocol_error   (protocol_error)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int a, input int b, input int c);
    return {5'(a), 5'(b), 5'(c)};
  endfunction

  function automatic logic [DW-1:0] rndName();
    logic [DW-1:0] w;
    int            code;
    w = '0;
    for (int i = 0; i < CH; i++) begin
      code = ($urandom_range(0, 15) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
      w = {w[DW-BB-1:0], 5'(code)};
    end
    return w;
  endfunction

  function automatic void pushByte(input logic [7:0] b);
    exp_q.push_back(b);
    m_count++;
  endfunction

  // Name text: each 5-bit code becomes 'a'+code, anything past 'z' is '?'.
  function automatic void pushName(input logic [DW-1:0] w);
    int code;
    for (int i = 0; i < CH; i++) begin
      code = (int'(w) >> (BB * (CH - 1 - i))) % 32;
      if (code < 26) begin
        pushByte(8'(97 + code));
      end else begin
        pushByte(8'h3F);
        m_err = 1'b1;
      end
    end
  endfunction

  // Text-level reference: a line opens with "src: ", each entry adds " dst"
  // after the first, and a last entry closes the line with a newline.
  function automatic void modelEntry(input logic [DW-1:0] dev, input logic [DW-1:0] nxt, input bit last);
    if (!m_open) begin
      pushName(dev);
      pushByte(8'h3A);
      m_src = dev;
    end else if (dev != m_src) begin
      m_err = 1'b1;
    end
    pushByte(8'h20);
    pushName(nxt);
    if (last) begin
      pushByte(8'h0A);
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endfunction

  function automatic void modelEof();
    if (m_open) begin
      pushByte(8'h0A);
    end
    m_open     = 1'b0;
    eof_issued = 1'b1;
  endfunction

  // Sink backpressure: always off, always on, or random stalls.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       byte_ready = 1'b0;
        1:       byte_ready = 1'b1;
        default: byte_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and watches end_of_stream.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (test_logic_reset) begin
        held     = 1'b0;
        eos_prev = 1'b0;
        eos_due  = 1'b0;
      end else begin
        if (eos_due) begin
          checkOutput("eos_after_last_byte", end_of_stream, 1);
          eos_due = 1'b0;
        end
        if (end_of_stream) begin
          eos_count++;
          checkOutput("eos_pulse_width", eos_prev, 0);
          checkOutput("eos_queue_drained", exp_q.size(), 0);
          checkOutput("eos_after_eof", eof_issued, 1);
        end
        eos_prev = end_of_stream;
        if (held && byte_valid) begin
          checkOutput("data_stable_under_stall", byte_data, held_data);
        end
        if (byte_valid && byte_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_byte actual=%0h expected=none at %0t", byte_data, $time);
          end else begin
            e = exp_q.pop_front();
            checkOutput("byte_data", byte_data, e);
            if (exp_q.size() == 0 && eof_issued) begin
              eos_due = 1'b1;
            end
          end
        end
        held      = byte_valid && !byte_ready;
        held_data = byte_data;
      end
    end
  end

  task automatic checkResetState();
    checkOutput("reset_connection_ready", connection_ready, 0);
    checkOutput("reset_byte_valid", byte_valid, 0);
    checkOutput("reset_byte_data", byte_data, 0);
    checkOutput("reset_end_of_stream", end_of_stream, 0);
    checkOutput("reset_byte_count", byte_count, 0);
    checkOutput("reset_protocol_error", protocol_error, 0);
  endtask

  task automatic doReset();
    test_logic_reset = 1'b1;
    connection_valid = 1'b0;
    end_of_file      = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    eof_issued = 1'b0;
    m_open     = 1'b0;
    m_src      = '0;
    m_err      = 1'b0;
    m_count    = 0;
    checkResetState();
    @(posedge clk);
    #1;
    test_logic_reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Presents one entry once the encoder can take it; optional same-cycle EOF.
  task automatic applyStimulus(input logic [DW-1:0] dev, input logic [DW-1:0] nxt, input bit last, input bit eof_too);
    int k;
    k = 0;
    while (!connection_ready && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!connection_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL entry_accept_timeout actual=ready_low expected=ready_high at %0t", $time);
      return;
    end
    device           = dev;
    next_device      = nxt;
    connection_last  = last;
    connection_valid = 1'b1;
    end_of_file      = eof_too;
    modelEntry(dev, nxt, last);
    if (eof_too) begin
      modelEof();
    end
    @(posedge clk);
    #1;
    connection_valid = 1'b0;
    end_of_file      = 1'b0;
  endtask

  task automatic sendEof();
    end_of_file = 1'b1;
    modelEof();
    @(posedge clk);
    #1;
    end_of_file = 1'b0;
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic waitEos();
    int k;
    int start;
    k     = 0;
    start = eos_count;
    while (eos_count == start && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (eos_count == start) begin
      checks++;
      errors++;
      $display("[TB] FAIL eos_timeout actual=no_pulse expected=pulse at %0t", $time);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("byte_count", byte_count, m_count);
    checkOutput("protocol_error", protocol_error, m_err);
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  // Safety net in case the run stops making progress.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    int            k;
    int            n;
    int            start;
    bit            open_line;
    bit            last;
    bit            eof_too;
    logic [DW-1:0] src;
    logic [DW-1:0] dev;

    ready_mode = 1;
    doReset();
    checkOutput("ready_after_reset", connection_ready, 1);

    $display("[TB] single entry you -> out, sink always ready");
    applyStimulus(mk(24, 14, 20), mk(14, 20, 19), 1'b1, 1'b0);
    checkOutput("first_byte_latency", byte_valid, 1);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    checkOutput("count_after_9_cycles", byte_count, 9);
    checkOutput("idle_after_line", byte_valid, 0);
    sendEof();
    waitEos();

    $display("[TB] two-entry line aaa: bbb ccc");
    doReset();
    applyStimulus(mk(0, 0, 0), mk(1, 1, 1), 1'b0, 1'b0);
    applyStimulus(mk(0, 0, 0), mk(2, 2, 2), 1'b1, 1'b0);
    sendEof();
    waitEos();

    $display("[TB] same line with random sink stalls");
    doReset();
    ready_mode = 2;
    applyStimulus(mk(0, 0, 0), mk(1, 1, 1), 1'b0, 1'b0);
    applyStimulus(mk(0, 0, 0), mk(2, 2, 2), 1'b1, 1'b0);
    sendEof();
    waitEos();

    $display("[TB] open line closed by end_of_file while busy");
    doReset();
    applyStimulus(mk(0, 0, 0), mk(1, 1, 1), 1'b0, 1'b0);
    sendEof();
    waitEos();
    ready_mode = 1;

    $display("[TB] entry and end_of_file in the same cycle");
    doReset();
    applyStimulus(mk(0, 0, 0), mk(1, 1, 1), 1'b0, 1'b1);
    waitEos();

    $display("[TB] invalid char code in next_device");
    doReset();
    applyStimulus(mk(0, 0, 0), mk(0, 27, 2), 1'b0, 1'b0);
    waitDrain();
    checkOutput("err_after_invalid", protocol_error, 1);
    applyStimulus(mk(0, 0, 0), mk(25, 25, 25), 1'b1, 1'b0);
    sendEof();
    waitEos();

    $display("[TB] continuation entry with a different source");
    doReset();
    applyStimulus(mk(0, 0, 0), mk(1, 1, 1), 1'b0, 1'b0);
    waitDrain();
    checkOutput("err_clean_line", protocol_error, 0);
    applyStimulus(mk(1, 1, 1), mk(2, 2, 2), 1'b1, 1'b0);
    sendEof();
    waitEos();

    $display("[TB] reset in the middle of a line");
    doReset();
    applyStimulus(mk(0, 0, 0), mk(1, 1, 1), 1'b1, 1'b0);
    k = 0;
    while (byte_count != 4 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("bytes_before_reset", byte_count, 4);
    ready_mode = 0;
    byte_ready = 1'b0;
    doReset();
    ready_mode = 1;
    applyStimulus(mk(2, 2, 2), mk(3, 3, 3), 1'b1, 1'b0);
    sendEof();
    waitEos();

    $display("[TB] end_of_file with no entries, then a second pulse");
    doReset();
    sendEof();
    waitEos();
    start = eos_count;
    sendEof();
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    checkOutput("second_eof_ignored", eos_count, start);
    checkOutput("no_entries_after_done", connection_ready, 0);

    $display("[TB] randomized streams");
    for (int it = 0; it < 6; it++) begin
      doReset();
      ready_mode = 2;
      n          = int'($urandom_range(1, 6));
      open_line  = 1'b0;
      src        = '0;
      eof_too    = 1'b0;
      for (int j = 0; j < n; j++) begin
        if (!open_line) begin
          dev = rndName();
          src = dev;
        end else begin
          dev = ($urandom_range(0, 7) == 0) ? rndName() : src;
        end
        last      = ($urandom_range(0, 2) == 0);
        eof_too   = (j == n - 1) && ($urandom_range(0, 1) == 1);
        applyStimulus(dev, rndName(), last, eof_too);
        open_line = !last;
      end
      if (!eof_too) begin
        sendEof();
      end
      waitEos();
    end
    ready_mode = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/connection_encoder.md
Name: connection_encoder

Overview:
- Inverse of the puzzle input decoder.
- Consumes decoded connection entries (device, next_device, last flag) and regenerates the ASCII puzzle text, one byte per handshake, in the form "abc: def ghi\n".
- Used for loopback self-check: the encoder's byte stream is fed back through the TAP result path or compared against the original input.
- Sits downstream of the connection source and upstream of any byte sink with backpressure.

Parameters:
- DEVICE_CHARS, 3, characters per device name.
- DEVICE_BIN_BITS, 5, bits per character code; code = ASCII - 'a'.
- DEVICE_WIDTH, DEVICE_CHARS*DEVICE_BIN_BITS, packed device width; char 0 (leftmost) in the MSBs.
- COUNT_WIDTH, 16, width of the emitted byte counter.

Ports:
- clk  in  1  clock.
- test_logic_reset  in  1  synchronous, active-high reset.
- connection_valid  in  1  entry present.
- connection_ready  out  1  entry accepted when valid&ready.
- connection_last  in  1  entry is the final destination of its device line.
- device  in  DEVICE_WIDTH  source device code.
- next_device  in  DEVICE_WIDTH  destination device code.
- end_of_file  in  1  single-cycle pulse: no further entries.
- byte_valid  out  1  output byte present.
- byte_ready  in  1  sink accepts when valid&ready.
- byte_data  out  8  ASCII byte.
- end_of_stream  out  1  one-cycle pulse after the final byte is accepted.
- byte_count  out  COUNT_WIDTH  bytes accepted by the sink; saturates at all-ones.
- protocol_error  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values:
  - connection_ready=0, byte_valid=0, byte_data=0x00, end_of_stream=0, byte_count=0, protocol_error=0.
  - FSM=IDLE, line_open=0, eof_pending=0.
  - Reset mid-line discards the partial line; no newline is emitted.
- connection_ready=1 only in IDLE with eof_pending=0 and byte_valid=0. An entry is captured into device_q, next_q and last_q on acceptance.
- FSM states: IDLE, SRC, COLON, SEP, DST, NEWLINE, DONE.
  - IDLE, accepted entry with line_open=0 -> SRC.
  - IDLE, accepted entry with line_open=1 -> SEP.
  - IDLE, eof_pending=1 and line_open=1 -> NEWLINE.
  - IDLE, eof_pending=1 and line_open=0 -> DONE.
  - SRC: emits DEVICE_CHARS chars of device_q (idx 0..2), then -> COLON.
  - COLON: emits ':' (0x3A) -> SEP.
  - SEP: emits ' ' (0x20) -> DST.
  - DST: emits chars of next_q. After the last char: last_q=1 -> NEWLINE; else -> IDLE with line_open=1.
  - NEWLINE: emits 0x0A, clears line_open. -> DONE if eof_pending=1, else IDLE.
  - DONE: asserts end_of_stream for one cycle, then stays idle. No further entries are accepted until reset.
- Each emitting state advances only on byte_valid&byte_ready. byte_data and byte_valid are registered and held stable while ready=0.
- Latency: entry accepted on cycle N -> first byte valid on N+1. With byte_ready held at 1, one byte is emitted per cycle.
- Char mapping: code c<26 -> 0x61+c. Code 26..31 -> '?' (0x3F) and sets protocol_error.
- Boundary and error conditions:
  - Non-first entry of an open line: its device is ignored for output. If it differs from the line's source device, protocol_error is set.
  - end_of_file may arrive at any state. It is latched into eof_pending and acted on at the next IDLE.
  - end_of_file while the FSM is busy is not lost.
  - A second end_of_file pulse is ignored.
  - end_of_file with no prior entries -> end_of_stream with zero bytes.
  - connection_valid and end_of_file in the same IDLE cycle: the entry is accepted first, and EOF is handled after that line segment.
- byte_count increments on each accepted byte and saturates at 0xFFFF for the default width.

Test Plan:
- Entry device={y,o,u}={24,14,20}, next={o,u,t}, last=1, byte_ready=1 -> bytes 79 6F 75 3A 20 6F 75 74 0A on consecutive cycles; byte_count=9.
- Two entries aaa->bbb (last=0) and aaa->ccc (last=1), then end_of_file -> "aaa: bbb ccc\n". end_of_stream pulses one cycle after the final 0x0A; byte_count=13.
- Random byte_ready stalls during the same stream -> identical byte sequence; byte_data is stable whenever valid&!ready.
- Entry with last=0 followed by end_of_file -> "aaa: bbb\n", with the newline auto-closing the line. end_of_stream follows.
- Char code 27 in next_device -> '?' emitted and protocol_error=1. A second entry aaa then zzz in the same line (last=0 then last=1) -> protocol_error stays 1.
- test_logic_reset asserted after 4 bytes of a line -> all outputs return to reset values next cycle. A fresh entry produces a clean line starting with the source chars.
